// File: rtl/video_planar.sv
// Raster timing generator and 1-bpp planar fetch/serialiser producing 9-bit RGB.
// Latency: a group fetched during hCount 8k..8k+7 is displayed at hCount 8k+8..8k+15.
// Backpressure: none; all counter/pixel state advances only on ce, palette writes ignore ce.
module video_planar #(
    parameter int HTOTAL       = 448,
    parameter int VTOTAL       = 312,
    parameter int HACTIVE      = 256,
    parameter int VACTIVE      = 248,
    parameter int HBLANK_START = 320,
    parameter int HBLANK_END   = 415,
    parameter int HSYNC_START  = 344,
    parameter int HSYNC_END    = 375,
    parameter int VBLANK_START = 248,
    parameter int VBLANK_END   = 255,
    parameter int VSYNC_START  = 260,
    parameter int VSYNC_END    = 263,
    parameter int INT_LEN      = 64,
    parameter int PLANES       = 4,
    localparam int HBITS       = $clog2(HACTIVE),
    localparam int VBITS       = $clog2(VACTIVE)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ce,
    input  logic [1:0]               mode,
    input  logic [8:0]               int_line,
    input  logic [8:0]               border,
    input  logic                     pal_we,
    input  logic [3:0]               pal_addr,
    input  logic [8:0]               pal_data,
    input  logic [7:0]               d,
    output logic [VBITS+HBITS-4:0]   a,
    output logic [1:0]               b,
    output logic                     hSync,
    output logic                     vSync,
    output logic                     hBlank,
    output logic                     vBlank,
    output logic [1:0]               sync,
    output logic                     int_n,
    output logic [8:0]               rgb
);

    // Counter widths cover the full line/frame, which may exceed the fetched area.
    localparam int HW   = $clog2(HTOTAL);
    localparam int VW   = $clog2(VTOTAL);
    // Index of the plane taken straight from d at phase 7 instead of an input register.
    localparam int LAST = PLANES - 1;

    localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic [2:0]    phase;
    logic          data_enable;
    logic          video_enable;
    logic          group_load;

    // Input registers hold the planes captured earlier in the group; shift registers
    // present the current pixel at bit 7. Plane order: 0 blue, 1 red, 2 green-x, 3 green.
    logic [7:0]    in_reg [4];
    logic [7:0]    shreg  [4];
    logic [1:0]    mode_reg;
    logic [8:0]    palette [16];

    logic          pix_b;
    logic          pix_r;
    logic          pix_gx;
    logic          pix_g;
    logic [8:0]    colour;

    assign phase       = h_count[2:0];
    assign data_enable = (int'(h_count) < HACTIVE) && (int'(v_count) < VACTIVE);
    // A group is committed to the shifters only on its last phase while the fetch window is open.
    assign group_load  = (phase == 3'd7) && video_enable;

    // Pixel and line counters, both frozen while ce is low
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (ce) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                if (v_count == V_LAST) begin
                    v_count <= '0;
                end else begin
                    v_count <= v_count + 1'b1;
                end
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    // videoEnable samples dataEnable during the second half of every group, so it lags the
    // fetch window by a few pixels at both ends of the line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            video_enable <= 1'b0;
        end else if (ce && h_count[2]) begin
            video_enable <= data_enable;
        end
    end

    // Plane capture, group load into the shifters (with mode capture), otherwise shift left
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) begin
                in_reg[p] <= '0;
                shreg[p]  <= '0;
            end
            mode_reg <= '0;
        end else if (ce) begin
            if (data_enable) begin
                for (int p = 0; p < LAST; p++) begin
                    if (int'(phase) == 2 * p + 1) begin
                        in_reg[p] <= d;
                    end
                end
            end
            if (group_load) begin
                for (int p = 0; p < 4; p++) begin
                    if (p < LAST) begin
                        shreg[p] <= in_reg[p];
                    end else if (p == LAST) begin
                        shreg[p] <= d;
                    end else begin
                        shreg[p] <= '0;
                    end
                end
                mode_reg <= mode;
            end else begin
                for (int p = 0; p < 4; p++) begin
                    shreg[p] <= {shreg[p][6:0], 1'b0};
                end
            end
        end
    end

    // Palette: reset contents reproduce the direct-RGB mapping; writes ignore ce
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= {{3{i[1]}}, {3{i[3]}}, {3{i[0]}}};
            end
        end else if (pal_we) begin
            palette[pal_addr] <= pal_data;
        end
    end

    // Colour selection from the shifter MSBs under the mode latched with the group
    always_comb begin
        pix_b  = shreg[0][7];
        pix_r  = shreg[1][7];
        pix_gx = shreg[2][7];
        pix_g  = shreg[3][7];
        colour = {{3{pix_r}}, {3{pix_g}}, {3{pix_b}}};
        case (mode_reg)
            2'd1:    colour = {{3{pix_r}}, {3{pix_gx}}, {3{pix_b}}};
            2'd2:    colour = palette[{pix_g, pix_gx, pix_r, pix_b}];
            default: colour = {{3{pix_r}}, {3{pix_g}}, {3{pix_b}}};
        endcase
    end

    // Output pixel: blanking beats border, border beats fetched colour
    always_comb begin
        if (hBlank || vBlank) begin
            rgb = '0;
        end else if (!video_enable) begin
            rgb = border;
        end else begin
            rgb = colour;
        end
    end

    assign hBlank = (int'(h_count) >= HBLANK_START) && (int'(h_count) <= HBLANK_END);
    assign hSync  = (int'(h_count) >= HSYNC_START)  && (int'(h_count) <= HSYNC_END);
    assign vBlank = (int'(v_count) >= VBLANK_START) && (int'(v_count) <= VBLANK_END);
    assign vSync  = (int'(v_count) >= VSYNC_START)  && (int'(v_count) <= VSYNC_END);
    assign sync   = {1'b1, ~(hSync | vSync)};

    // An int_line beyond the frame can never equal v_count, so it simply never fires.
    assign int_n  = !((int'(v_count) == int'(int_line)) &&
                      (int'(h_count) >= 2) && (int'(h_count) <= INT_LEN + 1));

    assign a = {v_count[VBITS-1:0], h_count[HBITS-1:3]};
    assign b = h_count[2:1];

endmodule

// File: tb/tb_video_planar.sv
// Bench for video_planar on a reduced raster so whole frames fit in a short run.
// Reference model tracks line/pixel position, captured planes and pixel age per group.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units after.
module tb_video_planar;

    localparam int HT   = 96;
    localparam int VT   = 40;
    localparam int HACT = 64;
    localparam int VACT = 30;
    localparam int HBS  = 80;
    localparam int HBE  = 91;
    localparam int HSS  = 84;
    localparam int HSE  = 87;
    localparam int VBS  = 32;
    localparam int VBE  = 35;
    localparam int VSS  = 36;
    localparam int VSE  = 37;
    localparam int ILEN = 16;
    localparam int HB   = $clog2(HACT);
    localparam int VB   = $clog2(VACT);
    localparam int AW   = VB + HB - 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ce = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [8:0]    int_line = 9'd0;
    logic [8:0]    border = 9'd0;
    logic          pal_we = 1'b0;
    logic [3:0]    pal_addr = 4'd0;
    logic [8:0]    pal_data = 9'd0;
    logic [7:0]    d = 8'd0;
    logic [AW-1:0] a;
    logic [1:0]    b;
    logic          hSync, vSync, hBlank, vBlank;
    logic [1:0]    sync;
    logic          int_n;
    logic [8:0]    rgb;

    int checks = 0;
    int failures = 0;

    // reference model state
    int         mh, mv, mage;
    bit         mve;
    logic [7:0] mcap [3];
    logic [7:0] mdisp [4];
    logic [1:0] mmode;
    logic [8:0] mpal [16];

    video_planar #(
        .HTOTAL(HT), .VTOTAL(VT), .HACTIVE(HACT), .VACTIVE(VACT),
        .HBLANK_START(HBS), .HBLANK_END(HBE), .HSYNC_START(HSS), .HSYNC_END(HSE),
        .VBLANK_START(VBS), .VBLANK_END(VBE), .VSYNC_START(VSS), .VSYNC_END(VSE),
        .INT_LEN(ILEN), .PLANES(4)
    ) dut (
        .clock(clock), .reset(reset), .ce(ce), .mode(mode), .int_line(int_line),
        .border(border), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .d(d), .a(a), .b(b), .hSync(hSync), .vSync(vSync), .hBlank(hBlank),
        .vBlank(vBlank), .sync(sync), .int_n(int_n), .rgb(rgb)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mve = 0; mage = 8; mmode = 2'd0;
        for (int p = 0; p < 3; p++) mcap[p] = 8'd0;
        for (int p = 0; p < 4; p++) mdisp[p] = 8'd0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] k;
            k = 4'(i);
            mpal[i] = {{3{k[1]}}, {3{k[3]}}, {3{k[0]}}};
        end
    endtask

    function automatic logic pbit(input int p);
        return (mage < 8) ? mdisp[p][7 - mage] : 1'b0;
    endfunction

    function automatic logic [8:0] exp_rgb();
        logic r, g, gx, bl;
        logic [8:0] col;
        bl = pbit(0); r = pbit(1); gx = pbit(2); g = pbit(3);
        case (mmode)
            2'd1:    col = {{3{r}}, {3{gx}}, {3{bl}}};
            2'd2:    col = mpal[{g, gx, r, bl}];
            default: col = {{3{r}}, {3{g}}, {3{bl}}};
        endcase
        if ((mh >= HBS && mh <= HBE) || (mv >= VBS && mv <= VBE)) return 9'd0;
        if (!mve) return border;
        return col;
    endfunction

    // one clock edge of the reference behaviour, using the inputs as currently driven
    task automatic model_edge();
        int ph;
        bit de;
        if (pal_we) mpal[pal_addr] = pal_data;
        if (!ce) return;
        ph = mh % 8;
        de = (mh < HACT) && (mv < VACT);
        if (de && (ph == 1 || ph == 3 || ph == 5)) mcap[ph / 2] = d;
        if (ph == 7 && mve) begin
            for (int p = 0; p < 3; p++) mdisp[p] = mcap[p];
            mdisp[3] = d;
            mage = 0;
            mmode = mode;
        end else if (mage < 8) begin
            mage++;
        end
        if (ph >= 4) mve = de;
        mh++;
        if (mh == HT) begin
            mh = 0;
            mv = (mv + 1) % VT;
        end
    endtask

    task automatic compare_all();
        bit hs, vs, hb, vb, irq;
        hs = (mh >= HSS && mh <= HSE);
        vs = (mv >= VSS && mv <= VSE);
        hb = (mh >= HBS && mh <= HBE);
        vb = (mv >= VBS && mv <= VBE);
        irq = (mv == int'(int_line)) && (mh >= 2) && (mh <= ILEN + 1);
        chk("hSync", 32'(hSync), 32'(hs));
        chk("vSync", 32'(vSync), 32'(vs));
        chk("hBlank", 32'(hBlank), 32'(hb));
        chk("vBlank", 32'(vBlank), 32'(vb));
        chk("sync", 32'(sync), 32'({1'b1, ~(hs | vs)}));
        chk("int_n", 32'(int_n), 32'(!irq));
        chk("rgb", 32'(rgb), 32'(exp_rgb()));
        chk("a", 32'(a), ((mv % (1 << VB)) * (HACT / 8)) + ((mh % HACT) / 8));
        chk("b", 32'(b), (mh / 2) % 4);
    endtask

    task automatic pre();
        #1;
        compare_all();
    endtask

    task automatic post();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pal_we = 1'b0;
        #3;
        model_reset();
        reset = 1'b0;
    endtask

    // line 0 groups 0 and 1 carry A5/0F/00/FF on phases 1/3/5/7; pixels 8..23 checked
    task automatic group_run(input string tag, input logic [1:0] m_first, input logic [1:0] m_late,
                             input bit all_ff, input bit pal_wr, input logic [8:0] e [16]);
        do_reset();
        mode = m_first;
        border = 9'h0AA;
        for (int i = 0; i < 24; i++) begin
            ce = 1'b1;
            pal_we = pal_wr && (i == 0);
            pal_addr = 4'hF;
            pal_data = 9'h1C7;
            if (i == 10) mode = m_late;
            case (i % 8)
                1:       d = 8'hA5;
                3:       d = 8'h0F;
                5:       d = 8'h00;
                7:       d = 8'hFF;
                default: d = 8'($urandom);
            endcase
            if (all_ff) d = 8'hFF;
            pre();
            if (i >= 8) chk(tag, 32'(rgb), 32'(e[i - 8]));
            post();
        end
        pal_we = 1'b0;
    endtask

    initial begin
        logic [8:0] e_m0 [16];
        logic [8:0] e_m1 [16];
        logic [8:0] e_pal [16];
        int hs_line, vs_cycles, vs_lines, hs_total, irq_cnt, irq_v, irq_h;

        e_m0 = '{9'h03F, 9'h038, 9'h03F, 9'h038, 9'h1F8, 9'h1FF, 9'h1F8, 9'h1FF,
                 9'h03F, 9'h038, 9'h03F, 9'h038, 9'h1F8, 9'h1FF, 9'h1F8, 9'h1FF};
        e_m1 = '{9'h007, 9'h000, 9'h007, 9'h000, 9'h1C0, 9'h1C7, 9'h1C0, 9'h1C7,
                 9'h03F, 9'h038, 9'h03F, 9'h038, 9'h1F8, 9'h1FF, 9'h1F8, 9'h1FF};
        for (int i = 0; i < 16; i++) e_pal[i] = 9'h1C7;

        // reset state, interrupt on line 0 starting at hCount 2
        int_line = 9'd0;
        border = 9'h123;
        do_reset();
        ce = 1'b1;
        pre();
        chk("rst_rgb", 32'(rgb), 32'h123);
        chk("rst_sync", 32'(sync), 32'h3);
        chk("rst_int_n", 32'(int_n), 32'h1);
        chk("rst_a", 32'(a), 32'h0);
        chk("rst_b", 32'(b), 32'h0);
        post();
        pre();
        chk("int_h1", 32'(int_n), 32'h1);
        post();
        pre();
        chk("int_h2", 32'(int_n), 32'h0);
        post();

        // direct RGB, alt-green with a mode change at hCount 10, palette entry F
        int_line = 9'd45;
        group_run("grp_mode0", 2'd0, 2'd0, 1'b0, 1'b0, e_m0);
        group_run("grp_mode1", 2'd1, 2'd0, 1'b0, 1'b0, e_m1);
        group_run("grp_pal", 2'd2, 2'd2, 1'b1, 1'b1, e_pal);

        // one full frame from reset: sync widths, border rows, out-of-range interrupt line
        do_reset();
        mode = 2'd0;
        border = 9'h155;
        ce = 1'b1;
        hs_line = 0; hs_total = 0; vs_cycles = 0; vs_lines = 0; irq_cnt = 0;
        for (int i = 0; i < HT * VT; i++) begin
            d = 8'($urandom);
            pre();
            if (hSync) begin hs_line++; hs_total++; end
            if (vSync) vs_cycles++;
            if (vSync && mh == 0) vs_lines++;
            if (!int_n) irq_cnt++;
            if (mv == 31 && mh == 10) chk("border_row", 32'(rgb), 32'h155);
            if (mv == 31 && mh == 85) chk("hblank_zero", 32'(rgb), 32'h0);
            if (mh == HT - 1) begin
                chk("hsync_per_line", hs_line, HSE - HSS + 1);
                hs_line = 0;
            end
            post();
        end
        pre();
        chk("wrap_a", 32'(a), 32'h0);
        chk("wrap_b", 32'(b), 32'h0);
        chk("hsync_total", hs_total, (HSE - HSS + 1) * VT);
        chk("vsync_cycles", vs_cycles, (VSE - VSS + 1) * HT);
        chk("vsync_lines", vs_lines, VSE - VSS + 1);
        chk("int_never", irq_cnt, 0);
        post();

        // interrupt on line 20: one burst of ILEN clocks per frame from hCount 2
        int_line = 9'd20;
        irq_cnt = 0; irq_v = -1; irq_h = -1;
        for (int i = 0; i < HT * VT; i++) begin
            d = 8'($urandom);
            pre();
            if (!int_n) begin
                if (irq_cnt == 0) begin irq_v = mv; irq_h = mh; end
                irq_cnt++;
            end
            post();
        end
        chk("int_count", irq_cnt, ILEN);
        chk("int_line_seen", irq_v, 20);
        chk("int_first_h", irq_h, 2);

        // randomized traffic: ce gaps, mode switches, palette writes, a reset mid-line
        for (int i = 0; i < 6000; i++) begin
            ce = ($urandom_range(0, 4) != 0);
            d = 8'($urandom);
            if (i % 64 == 0) mode = 2'($urandom);
            pal_we = ($urandom_range(0, 15) == 0);
            pal_addr = 4'($urandom);
            pal_data = 9'($urandom);
            if (i % 500 == 0) border = 9'($urandom);
            if (i % 1500 == 0) int_line = 9'($urandom_range(0, 47));
            if (i == 3333) begin
                do_reset();
                pre();
                chk("midrst_rgb", 32'(rgb), 32'(border));
                chk("midrst_a", 32'(a), 32'h0);
                chk("midrst_b", 32'(b), 32'h0);
                post();
            end else begin
                pre();
                post();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
